// File: rtl/md_unit_pkg.sv
// md_unit_pkg: opcode encoding and result computation for the multiply/divide unit.
package md_unit_pkg;
   typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_t;
   typedef struct packed {
      logic        ok;
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;
   // 33-bit signed operands make 0x80000000 / -1 wrap to 0x80000000 without overflow
   function automatic md_res_t md_calc(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0] up;
      logic [31:0] ub;
      logic signed [32:0] sa, sb;
      md_res_t r;
      ub = (b == '0) ? 32'd1 : b;
      sa = $signed({a[31], a});
      sb = $signed({ub[31], ub});
      sp = 64'($signed(a)) * 64'($signed(b));
      up = {32'd0, a} * {32'd0, b};
      r.ok = ((op == MD_DIV) || (op == MD_DIVU)) ? (b != '0) : 1'b1;
      r.hi = op == MD_MULT ? sp[63:32] : op == MD_MULTU ? up[63:32] : op == MD_DIV ? 32'(sa % sb) : a % ub;
      r.lo = op == MD_MULT ? sp[31:0] : op == MD_MULTU ? up[31:0] : op == MD_DIV ? 32'(sa / sb) : a / ub;
      return r;
   endfunction
endpackage

// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide unit with HI/LO registers.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hilowe,
   input  logic        hilo_A3,
   input  logic [1:0]  re_hi_loop,
   output logic        busy,
   output logic [31:0] md_rdata
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   logic [31:0] hi, lo, pend_hi, pend_lo;
   logic pend_ok, go, wr;
   logic [CW-1:0] cnt;
   md_res_t res;
   always_comb begin
      go = start & ~req & ~busy;
      wr = hilowe & ~req & ~busy & ~start;
      res = md_calc(md_op_t'(md_op), A, B);
      md_rdata = re_hi_loop == 2'b01 ? hi : re_hi_loop == 2'b10 ? lo : '0;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         hi <= '0;
         lo <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_ok <= 1'b0;
         cnt <= '0;
         busy <= 1'b0;
      end else if (go) begin
         pend_hi <= res.hi;
         pend_lo <= res.lo;
         pend_ok <= res.ok;
         cnt <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         busy <= 1'b1;
      end else if (busy) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            busy <= 1'b0;
            // a divide by zero still spends its cycles but leaves HI/LO alone
            if (pend_ok) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
         end
      end else if (wr) begin
         if (hilo_A3) lo <= A;
         else hi <= A;
      end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit with a behavioural HI/LO reference model.
module tb_md_unit;
   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES = 10;
   logic clk = 1'b0, reset_n = 1'b0, req = 1'b0, start = 1'b0, hilowe = 1'b0, hilo_A3 = 1'b0;
   logic [1:0] md_op = '0, re_hi_loop = '0;
   logic [31:0] A = '0, B = '0, md_rdata;
   logic busy, sample = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [31:0] exp_data[$];
   int exp_len[$];
   int errors = 0, checks = 0, run = 0;

   md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .start(start), .md_op(md_op), .A(A), .B(B),
      .hilowe(hilowe), .hilo_A3(hilo_A3), .re_hi_loop(re_hi_loop), .busy(busy), .md_rdata(md_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: measures each busy pulse and checks every flagged read
   always @(negedge clk) begin
      if (!reset_n) begin
         run = 0;
         exp_len.delete();
      end else begin
         if (busy) run++;
         else if (run > 0) begin
            if (exp_len.size() == 0) check("unexpected_busy", run, 0);
            else check("busy_len", run, exp_len.pop_front());
            run = 0;
         end
         if (sample) begin
            if (exp_data.size() == 0) check("read_no_expect", md_rdata, 'x);
            else check($sformatf("rdata_sel%0d", re_hi_loop), md_rdata, exp_data.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o == 2'd0) p = sa * sb;
      else p = {32'd0, a} * {32'd0, b};
      if (o < 2'd2) {m_hi, m_lo} = p;
      else if (b != 0) begin
         if (o == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
         end else begin
            q = longint'(a / b);
            r = longint'(a % b);
         end
         m_lo = q[31:0];
         m_hi = r[31:0];
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      md_op = o;
      A = a;
      B = b;
      tick();
      start = 1'b0;
      model(o, a, b);
      exp_len.push_back(o[1] ? DIV_CYCLES : MULT_CYCLES);
   endtask

   task automatic finish_op();
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      if (busy) check("busy_timeout", 32'(busy), 32'd0);
   endtask

   task automatic rd(input logic [1:0] sel, input logic [31:0] exp);
      re_hi_loop = sel;
      sample = 1'b1;
      exp_data.push_back(exp);
      tick();
      sample = 1'b0;
   endtask

   task automatic mt(input logic sel, input logic [31:0] a);
      hilowe = 1'b1;
      hilo_A3 = sel;
      A = a;
      tick();
      hilowe = 1'b0;
      if (sel) m_lo = a;
      else m_hi = a;
   endtask

   initial begin
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("reset_busy", 32'(busy), 32'd0);
      rd(2'b01, 32'd0);
      rd(2'b10, 32'd0);
      issue(2'd0, 32'hFFFFFFFE, 32'd3);
      finish_op();
      rd(2'b01, 32'hFFFFFFFF);
      rd(2'b10, 32'hFFFFFFFA);
      rd(2'b00, 32'd0);
      rd(2'b11, 32'd0);
      issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      finish_op();
      rd(2'b01, 32'hFFFFFFFE);
      rd(2'b10, 32'h00000001);
      issue(2'd2, 32'hFFFFFFF9, 32'd2);
      finish_op();
      rd(2'b10, 32'hFFFFFFFD);
      rd(2'b01, 32'hFFFFFFFF);
      issue(2'd3, 32'd7, 32'd2);
      finish_op();
      rd(2'b10, 32'd3);
      rd(2'b01, 32'd1);
      issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
      finish_op();
      rd(2'b10, 32'h80000000);
      rd(2'b01, 32'd0);
      mt(1'b0, 32'h12345678);
      rd(2'b01, 32'h12345678);
      issue(2'd2, 32'd99, 32'd0);
      finish_op();
      rd(2'b01, 32'h12345678);
      rd(2'b10, 32'h80000000);
      // start suppressed by req: no busy pulse, HI/LO unchanged
      start = 1'b1;
      req = 1'b1;
      md_op = 2'd0;
      A = 32'd5;
      B = 32'd6;
      tick();
      start = 1'b0;
      req = 1'b0;
      check("req_blocks_start", 32'(busy), 32'd0);
      rd(2'b01, 32'h12345678);
      rd(2'b10, 32'h80000000);
      // req and hilowe during an operation do not disturb it
      issue(2'd0, 32'd1000, 32'hFFFFFFFD);
      tick();
      req = 1'b1;
      hilowe = 1'b1;
      hilo_A3 = 1'b1;
      A = 32'hDEADBEEF;
      tick();
      req = 1'b0;
      hilowe = 1'b0;
      finish_op();
      rd(2'b01, m_hi);
      rd(2'b10, 32'hFFFFF448);
      // second start while busy is ignored
      issue(2'd1, 32'h00010000, 32'h00030000);
      tick();
      start = 1'b1;
      md_op = 2'd2;
      A = 32'd50;
      B = 32'd7;
      tick();
      start = 1'b0;
      finish_op();
      rd(2'b01, 32'h00000003);
      rd(2'b10, 32'h00000000);
      // reset mid-operation abandons it
      issue(2'd0, 32'd7, 32'd9);
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      re_hi_loop = 2'b01;
      #1;
      check("rst_hi", md_rdata, 32'd0);
      re_hi_loop = 2'b10;
      #1;
      check("rst_lo", md_rdata, 32'd0);
      m_hi = '0;
      m_lo = '0;
      tick();
      reset_n = 1'b1;
      repeat (MULT_CYCLES + 3) tick();
      rd(2'b01, 32'd0);
      rd(2'b10, 32'd0);
      // randomized operations and moves against the model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         int k;
         k = $urandom_range(0, 7);
         a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         b = k == 0 ? 32'd0 : k == 1 ? $urandom_range(1, 9) : k == 2 ? 32'hFFFFFFFF : $urandom;
         if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), a);
         else begin
            issue(2'($urandom_range(0, 3)), a, b);
            finish_op();
         end
         rd(2'b01, m_hi);
         rd(2'b10, m_lo);
      end
      tick();
      tick();
      check("pending_busy_checks", exp_len.size(), 0);
      check("pending_reads", exp_data.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
